// File: rtl/bram_write_arbiter.sv
// bram_write_arbiter
//   Round-robin arbiter that grants one of NUM_REQ burst writers exclusive use
//   of a single BRAM write port. A granted requester streams req_we beats; each
//   accepted beat appears on the BRAM port exactly one cycle later at
//   offset + beat index (16-bit wrap). Zero-length requests complete at once
//   without a grant.
//
// Optional feature (compile-time macro BRAM_ARB_TIMEOUT_EN):
//   aborts a burst after TIMEOUT consecutive cycles without a beat from the
//   owner, pulsing arb_err together with req_done.
//
// Parameters: NUM_REQ (2..8), DATA_W (line width), TIMEOUT (idle-beat limit)
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid[NUM_REQ]      burst request, held until req_done
//   req_offset/req_length   16 bits per requester (slice i = [16i+15:16i])
//   req_we, req_wdata       per-requester write beat and data
//   req_grant               one-hot owner of the write port
//   req_done                one-cycle completion pulse
//   bram_we/waddr/wdata     BRAM write port (registered)
//   arb_err                 one-cycle pulse on timeout abort
module bram_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*16-1:0]     req_offset,
  input  logic [NUM_REQ*16-1:0]     req_length,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      bram_we,
  output logic [15:0]               bram_waddr,
  output logic [DATA_W-1:0]         bram_wdata,
  output logic                      arb_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("bram_write_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [15:0]      cur_off;
  logic [15:0]      cur_len;
  logic [15:0]      beat_cnt;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;

  logic [15:0]       off_a   [NUM_REQ];
  logic [15:0]       len_a   [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign off_a[i]   = req_offset[16*i +: 16];
    assign len_a[i]   = req_length[16*i +: 16];
    assign wdata_a[i] = req_wdata[DATA_W*i +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    int unsigned n;
    n = (32'(i) + 32'd1) % NUM_REQ;
    return n[IDX_W-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  // (NUM_REQ need not be a power of two, so the wrap is explicit).
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req_valid[idx[IDX_W-1:0]]) begin
        pick     = idx[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

`ifdef BRAM_ARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cur_off    <= '0;
      cur_len    <= '0;
      beat_cnt   <= '0;
      req_grant  <= '0;
      req_done   <= '0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      arb_err    <= 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      bram_we  <= 1'b0;
      req_done <= '0;
      arb_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            if (len_a[pick] == '0) begin
              req_done <= onehot(pick);
              rr_ptr   <= next_idx(pick);
            end else begin
              owner     <= pick;
              cur_off   <= off_a[pick];
              cur_len   <= len_a[pick];
              beat_cnt  <= '0;
              req_grant <= onehot(pick);
              state     <= BURST;
`ifdef BRAM_ARB_TIMEOUT_EN
              idle_cnt  <= '0;
`endif
            end
          end
        end
        BURST: begin
          if (req_we[owner]) begin
            bram_we    <= 1'b1;
            bram_waddr <= cur_off + beat_cnt;
            bram_wdata <= wdata_a[owner];
            beat_cnt   <= beat_cnt + 16'd1;
`ifdef BRAM_ARB_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
            if (beat_cnt == cur_len - 16'd1) begin
              req_done  <= onehot(owner);
              req_grant <= '0;
              rr_ptr    <= next_idx(owner);
              state     <= IDLE;
            end
          end
`ifdef BRAM_ARB_TIMEOUT_EN
          else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            arb_err   <= 1'b1;
            req_done  <= onehot(owner);
            req_grant <= '0;
            rr_ptr    <= next_idx(owner);
            state     <= IDLE;
          end else begin
            idle_cnt  <= idle_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BRAM_ARB_TIMEOUT_EN
  // Without the timeout feature a burst waits for its owner indefinitely.
`endif

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Testbench for bram_write_arbiter: randomized traffic plus directed scenarios
// (address sequence, round-robin order, zero length, address wrap, stalled
// owner, reset mid-burst), checked by a transaction-level reference model.
`timescale 1ns/1ps
module tb_bram_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*16-1:0] req_offset = '0;
  logic [N*16-1:0] req_length = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    req_done;
  logic            bram_we;
  logic [15:0]     bram_waddr;
  logic [DW-1:0]   bram_wdata;
  logic            arb_err;

  bram_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_offset(req_offset), .req_length(req_length),
    .req_we(req_we), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          we;
    logic [15:0]   addr;
    logic [DW-1:0] data;
    logic [N-1:0]  done;
    logic          err;
  } ev_t;
  typedef struct {
    int           cyc;
    logic [N-1:0] grant;
  } gnt_t;

  ev_t  ev_q[$];
  gnt_t gnt_q[$];
  ev_t  me;
  gnt_t mg;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state: who owns the port, how far the burst has got,
  // and the round-robin starting point.
  logic [N-1:0] m_valid = '0;
  logic [15:0]  m_off [N];
  logic [15:0]  m_len [N];
  int owner = -1, ptr = 0, cnt = 0, idle = 0;
  int p_arrive = 0, p_we = 100, max_len = 6;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rand_off();
    if ($urandom_range(3) == 0) return 16'hFFFC + 16'($urandom_range(3));
    return 16'($urandom);
  endfunction

  task automatic new_req(input int i, input logic [15:0] off, input logic [15:0] len);
    m_valid[i] = 1'b1;
    m_off[i]   = off;
    m_len[i]   = len;
  endtask

  task automatic retire(inout ev_t e);
    e.done[owner] = 1'b1;
    m_valid[owner] = 1'b0;
    ptr   = (owner + 1) % N;
    owner = -1;
  endtask

  // One clock of stimulus; the expected consequences of the coming rising edge
  // are queued for the monitor.
  task automatic step();
    logic [N-1:0]  we_v;
    logic [DW-1:0] d [N];
    ev_t  e;
    gnt_t gq;
    bit   have_ev;
    int   g;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (!m_valid[i] && $urandom_range(99) < p_arrive)
        new_req(i, rand_off(), 16'($urandom_range(max_len)));
    for (int i = 0; i < N; i++) begin
      we_v[i] = (i == owner) ? ($urandom_range(99) < p_we) : 1'($urandom_range(1));
      d[i]    = {$urandom, $urandom};
      req_offset[16*i +: 16] = m_off[i];
      req_length[16*i +: 16] = m_len[i];
      req_wdata[DW*i +: DW]  = d[i];
    end
    req_valid = m_valid;
    req_we    = we_v;

    e = '{cyc: cyc + 1, we: 1'b0, addr: 16'h0, data: '0, done: '0, err: 1'b0};
    have_ev = 1'b0;
    if (owner < 0) begin
      g = -1;
      for (int k = 0; k < N && g < 0; k++)
        if (m_valid[(ptr + k) % N]) g = (ptr + k) % N;
      if (g >= 0) begin
        if (m_len[g] == 16'h0) begin
          e.done[g]  = 1'b1;
          have_ev    = 1'b1;
          m_valid[g] = 1'b0;
          ptr        = (g + 1) % N;
        end else begin
          owner = g; cnt = 0; idle = 0;
        end
      end
    end else if (we_v[owner]) begin
      e.we    = 1'b1;
      e.addr  = m_off[owner] + 16'(cnt);
      e.data  = d[owner];
      have_ev = 1'b1;
      idle    = 0;
      if (cnt == m_len[owner] - 1) retire(e);
      else cnt++;
    end else begin
      idle++;
`ifdef BRAM_ARB_TIMEOUT_EN
      if (idle == TO) begin
        e.err   = 1'b1;
        have_ev = 1'b1;
        retire(e);
      end
`endif
    end
    if (have_ev) ev_q.push_back(e);
    gq.cyc   = cyc + 1;
    gq.grant = (owner >= 0) ? (N'(1) << owner) : '0;
    gnt_q.push_back(gq);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    p_arrive = 0;
    while ((owner >= 0 || m_valid != '0) && n < bound) begin
      step();
      n++;
    end
    check("drain_bound", DW'(n >= bound), '0);
    step();
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    req_we    = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_grant", req_grant, '0);
    check("rst_done", req_done, '0);
    check("rst_bram_we", bram_we, '0);
    check("rst_waddr", bram_waddr, '0);
    check("rst_wdata", bram_wdata, '0);
    check("rst_arb_err", arb_err, '0);
    ev_q.delete();
    gnt_q.delete();
    m_valid = '0; owner = -1; ptr = 0; cnt = 0; idle = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (gnt_q.size() != 0 && gnt_q[0].cyc == cyc) begin
        mg = gnt_q.pop_front();
        check("req_grant", req_grant, mg.grant);
      end
      if (bram_we || req_done != '0 || arb_err) begin
        if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: we=%0b addr=%0h done=%b err=%0b, none expected (cycle %0d)",
                   bram_we, bram_waddr, req_done, arb_err, cyc);
        end else begin
          me = ev_q.pop_front();
          check("bram_we", bram_we, me.we);
          if (me.we) begin
            check("bram_waddr", bram_waddr, me.addr);
            check("bram_wdata", bram_wdata, me.data);
          end
          check("req_done", req_done, me.done);
          check("arb_err", arb_err, me.err);
        end
      end else if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
        me = ev_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_output: got nothing, expected we=%0b addr=%0h done=%b err=%0b (cycle %0d)",
                 me.we, me.addr, me.done, me.err, cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_off[i] = '0;
      m_len[i] = '0;
    end
    #1 reset_n = 1'b0;
    #1;
    check("init_grant", req_grant, '0);
    check("init_bram_we", bram_we, '0);
    check("init_waddr", bram_waddr, '0);
    check("init_done", req_done, '0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    mon_en = 1'b1;

    // Round-robin order 0,1,2,3 then 0 again, length 1 each.
    p_arrive = 0; p_we = 100;
    for (int i = 0; i < N; i++) new_req(i, 16'(16 * i), 16'd1);
    drain(50);
    new_req(0, 16'h0200, 16'd1);
    drain(20);

    // Three-beat burst from offset 0x0010.
    new_req(0, 16'h0010, 16'd3);
    drain(20);

    // Zero-length on requester 2; pointer must then favour requester 3.
    new_req(2, 16'h0055, 16'd0);
    drain(10);
    new_req(0, 16'h0300, 16'd1);
    new_req(3, 16'h0400, 16'd1);
    drain(20);

    // Address wrap through 0xFFFF.
    new_req(1, 16'hFFFE, 16'd4);
    drain(20);

    // Randomized traffic with stalls and foreign write beats.
    p_arrive = 25; p_we = 70; max_len = 6;
    repeat (1500) step();
    p_we = 100;
    drain(2000);

    // Owner goes silent.
    p_we = 0;
    new_req(3, 16'h0100, 16'd3);
    repeat (120) step();
    p_we = 100;
    drain(20);

    // Reset after 2 of 5 beats; pointer restarts at requester 0.
    p_we = 100;
    new_req(2, 16'h1234, 16'd5);
    for (int n = 0; n < 20 && !(owner == 2 && cnt == 2); n++) step();
    do_reset();
    repeat (5) step();
    for (int i = 0; i < N; i++) new_req(i, 16'(16'h0800 + i), 16'd1);
    drain(50);

    check("queue_empty", DW'(ev_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_write_arbiter.md
BRAM_WRITE_ARBITER -- requirements
Module: bram_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-002 Parameter DATA_W, default 512: BRAM line width in bits.
REQ-003 Parameter TIMEOUT, default 1024: idle-beat limit, used only with BRAM_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester burst request, held until done.
REQ-007 req_offset  in  NUM_REQ*16  per-requester start line address; slice i = [16i+15:16i].
REQ-008 req_length  in  NUM_REQ*16  per-requester burst length in lines; same slicing.
REQ-009 req_we  in  NUM_REQ  per-requester write-beat valid.
REQ-010 req_wdata  in  NUM_REQ*DATA_W  per-requester write data.
REQ-011 req_grant  out  NUM_REQ  one-hot; marks the owner of the BRAM write port.
REQ-012 req_done  out  NUM_REQ  one-cycle pulse at burst completion.
REQ-013 bram_we  out  1  BRAM write enable.
REQ-014 bram_waddr  out  16  BRAM write line address.
REQ-015 bram_wdata  out  DATA_W  BRAM write data.
REQ-016 arb_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 States: IDLE and BURST only.
REQ-018 IDLE: round-robin pick of the first set req_valid at or after pointer rr_ptr, wrapping modulo NUM_REQ.
REQ-019 IDLE, selected req_length != 0: latch offset and length, clear beat counter, set req_grant[g], go to BURST next cycle.
REQ-020 IDLE, selected req_length == 0: pulse req_done[g] next cycle, no grant, rr_ptr <= g+1, stay IDLE.
REQ-021 BURST: req_we[g] high while counter < length -> next cycle bram_we=1, bram_waddr=offset+counter (mod 2^16), bram_wdata=slice g, counter++.
REQ-022 Write latency is exactly one cycle from an accepted req_we beat to bram_we.
REQ-023 req_we from non-granted requesters is ignored; data is dropped and no state changes.
REQ-024 Last beat (counter == length-1) accepted: req_done[g] pulses in the same cycle as the final bram_we, req_grant clears, rr_ptr <= g+1 mod NUM_REQ, state returns to IDLE.
REQ-025 Requests are arbitrated only in IDLE; a newly arriving req_valid waits; no preemption.
REQ-026 At most one req_grant bit and at most one req_done bit are high in any cycle.
REQ-027 bram_we deasserts in every cycle with no accepted beat; bram_waddr and bram_wdata hold their last values.
REQ-028 After done, a requester whose req_valid is still high is re-arbitrated as a new request.

Reset
REQ-029 reset_n low asynchronously forces: state IDLE, rr_ptr 0, counter 0, req_grant 0, req_done 0, bram_we 0, bram_waddr 0, bram_wdata 0, arb_err 0.
REQ-030 Reset during BURST abandons the burst; no req_done is issued for it.
REQ-031 Outputs leave reset values no earlier than the first rising clk after reset_n rises.

Configuration
REQ-032 With BRAM_ARB_TIMEOUT_EN defined, BURST counts consecutive cycles without req_we[g].
REQ-033 With BRAM_ARB_TIMEOUT_EN, reaching TIMEOUT idle cycles: arb_err pulses, req_done[g] pulses, grant clears, rr_ptr <= g+1, state returns to IDLE.
REQ-034 Any accepted beat clears the idle counter.
REQ-035 Without BRAM_ARB_TIMEOUT_EN: no idle counter, arb_err tied 0, bursts wait indefinitely.

Verification
REQ-036 req_valid=0001, offset 0x0010, length 3, req_we high 3 cycles -> bram_waddr 0x10, 0x11, 0x12 on consecutive cycles; req_done[0] with third write.
REQ-037 req_valid=1111 held, length 1 each, req_we always high -> grants in order 0,1,2,3,0; never two grants high together.
REQ-038 Requester 2 length 0 -> req_done[2] pulses, no bram_we, rr_ptr moves to 3.
REQ-039 offset 0xFFFE, length 4 -> bram_waddr FFFE, FFFF, 0000, 0001.
REQ-040 reset_n low mid-burst after 2 of 5 beats -> all outputs zero immediately, no req_done; new request restarts arbitration at requester 0.
REQ-041 With BRAM_ARB_TIMEOUT_EN and TIMEOUT=8, granted requester silent 8 cycles -> arb_err and req_done pulse together, state IDLE; without the macro, the grant holds for 100+ cycles.
